// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit arbiter: opcodes and FSM state encoding.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_RESULT = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/result bus between two requesters, one consumer and the arbiter.
// Requester i occupies slice i of req_a/req_b (WIDTH bits) and req_op (2 bits).
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 8
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_op;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               res_id;

  // Requester/consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: AND / OR / XOR / NAND.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  // Opcode decode
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters.
// IDLE accepts one request, EXEC registers the result, RESULT holds it until taken.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] y;

  logic [WIDTH-1:0] res_data_q;
  logic             res_id_q;
  logic             res_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] done_count_q;

  // Round-robin grant: with contention the requester not served last time wins
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase

    req_ready = 2'b00;
    if (!rst && state == ST_IDLE && bus.req_valid[grant]) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end

    sel_a  = grant ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
    sel_b  = grant ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
    sel_op = grant ? bus.req_op[3:2]           : bus.req_op[1:0];
  end

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (y)
  );

  // FSM with registered result, status and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_ready) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            op_q       <= sel_op;
            id_q       <= grant;
            last_grant <= grant;
            busy_q     <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= y;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state       <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_count_q <= done_count_q + CNT_W'(1);
            state        <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign busy          = busy_q;
  assign done_count    = done_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] done_count;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  logic_unit_arbiter_if #(.WIDTH(8)) bus ();

  logic_unit_arbiter #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    bus.req_a[i*8 +: 8]  = a;
    bus.req_b[i*8 +: 8]  = b;
    bus.req_op[i*2 +: 2] = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    set_req(0, 8'h11, 8'h22, OP_AND);
    set_req(1, 8'h33, 8'h44, OP_OR);
    step();
    step();
    checks++; if (bus.req_ready !== 2'b00) begin failures++;
      $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++;
      $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h00) begin failures++;
      $display("FAIL reset_res_data: got %h expected 00", bus.res_data); end
    checks++; if (bus.res_id !== 1'b0) begin failures++;
      $display("FAIL reset_res_id: got %b expected 0", bus.res_id); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done_count !== 8'h00) begin failures++;
      $display("FAIL reset_done_count: got %h expected 00", done_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++;
      $display("FAIL reset_first_grant: got %b expected 01", bus.req_ready); end
    // Withdraw before the edge: no commitment, so nothing is accepted
    bus.req_valid = 2'b00;
    step();
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_withdraw_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    set_req(1, 8'hF0, 8'h3C, OP_XOR);
    bus.req_valid = 2'b10;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++;
      $display("FAIL single_req_ready: got %b expected 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    set_req(1, 8'h00, 8'h00, OP_AND);
    checks++; if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin failures++;
      $display("FAIL single_exec: got busy=%b res_valid=%b expected busy=1 res_valid=0",
               busy, bus.res_valid); end
    step();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hCC || bus.res_id !== 1'b1)
      begin failures++;
      $display("FAIL single_result: got v=%b data=%h id=%b expected v=1 data=cc id=1",
               bus.res_valid, bus.res_data, bus.res_id); end
    step();
    checks++; if (bus.res_valid !== 1'b0 || done_count !== 8'd1 || busy !== 1'b0)
      begin failures++;
      $display("FAIL single_done: got v=%b count=%0d busy=%b expected v=0 count=1 busy=0",
               bus.res_valid, done_count, busy); end
  endtask

  task automatic test_contention();
    int last_cyc = 0;
    logic [1:0] exp_ready;
    logic [7:0] exp_data;
    set_req(0, 8'hAA, 8'h0F, OP_AND);
    set_req(1, 8'hAA, 8'h0F, OP_NAND);
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data  = (k % 2 == 0) ? 8'h0A : 8'hF5;
      while (bus.req_ready == 2'b00 && t < 6) begin
        step();
        t++;
      end
      checks++; if (bus.req_ready !== exp_ready) begin failures++;
        $display("FAIL contention_grant_%0d: got %b expected %b", k, bus.req_ready, exp_ready);
      end
      if (k > 0) begin
        checks++; if (cyc - last_cyc != 3) begin failures++;
          $display("FAIL contention_spacing_%0d: got %0d expected 3", k, cyc - last_cyc); end
      end
      last_cyc = cyc;
      step();
      step();
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data ||
                    bus.res_id !== exp_ready[1]) begin failures++;
        $display("FAIL contention_result_%0d: got v=%b data=%h id=%b expected v=1 data=%h id=%b",
                 k, bus.res_valid, bus.res_data, bus.res_id, exp_data, exp_ready[1]); end
      step();
    end
    bus.req_valid = 2'b00;
    checks++; if (done_count !== 8'd5) begin failures++;
      $display("FAIL contention_count: got %0d expected 5", done_count); end
  endtask

  task automatic test_backpressure();
    set_req(0, 8'h12, 8'h40, OP_OR);
    bus.req_valid = 2'b01;
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++;
      $display("FAIL bp_req_ready: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    bus.req_valid = 2'b11;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h52 || bus.res_id !== 1'b0 ||
                    bus.req_ready !== 2'b00 || done_count !== 8'd5) begin failures++;
        $display("FAIL bp_stall_%0d: got v=%b data=%h id=%b rdy=%b cnt=%0d expected 1 52 0 00 5",
                 s, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready, done_count); end
      if (s < 4) step();
    end
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b1;
    step();
    checks++; if (bus.res_valid !== 1'b0 || done_count !== 8'd6 || busy !== 1'b0)
      begin failures++;
      $display("FAIL bp_release: got v=%b count=%0d busy=%b expected v=0 count=6 busy=0",
               bus.res_valid, done_count, busy); end
  endtask

  task automatic test_mid_reset();
    set_req(1, 8'hFF, 8'hFF, OP_AND);
    bus.req_valid = 2'b10;
    bus.res_ready = 1'b1;
    step();
    bus.req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL midrst_exec: got busy=%b expected 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0 || done_count !== 8'd0)
      begin failures++;
      $display("FAIL midrst_idle: got busy=%b v=%b count=%0d expected 0 0 0",
               busy, bus.res_valid, done_count); end
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (bus.res_valid !== 1'b0 || done_count !== 8'd0) begin failures++;
        $display("FAIL midrst_quiet_%0d: got v=%b count=%0d expected 0 0",
                 s, bus.res_valid, done_count); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_tab [4];
    logic [1:0] op_k;
    exp_tab[0] = 8'h12;
    exp_tab[1] = 8'h7B;
    exp_tab[2] = 8'h69;
    exp_tab[3] = 8'hED;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      op_k = 2'(k);
      set_req(0, 8'h5A, 8'h33, op_k);
      bus.req_valid = 2'b01;
      step();
      step();
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp_tab[op_k]) begin failures++;
        $display("FAIL wrap_result_%0d: got v=%b data=%h expected v=1 data=%h",
                 k, bus.res_valid, bus.res_data, exp_tab[op_k]); end
      step();
      if (k == 254) begin
        checks++; if (done_count !== 8'd255) begin failures++;
          $display("FAIL wrap_count_255: got %0d expected 255", done_count); end
      end
    end
    bus.req_valid = 2'b00;
    checks++; if (done_count !== 8'd0) begin failures++;
      $display("FAIL wrap_count_0: got %0d expected 0", done_count); end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.res_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 8-bit bitwise logic unit (AND/OR/XOR/NAND) between two requesters. Round-robin arbitration and a valid/ready handshake on each request port, a registered compute stage, and a held result port with a requester tag. It sits between the pin-facing input capture (`ui_in` / `uio_in` operand sources) and the `uo_out` driver. It replaces the fixed `a & b` path with a sequenced, shared operation unit.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width in bits
- `CNT_W`, 8, width of the completed-operation counter

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge
- `rst`  in  1  — synchronous, active-high reset
- `req_valid`  in  2  — bit i: requester i presents an operation
- `req_ready`  out  2  — bit i: requester i's operation is accepted this cycle
- `req_a`  in  2*WIDTH  — operand A; requester i in bits [i*WIDTH +: WIDTH]
- `req_b`  in  2*WIDTH  — operand B; same packing as `req_a`
- `req_op`  in  4  — opcode; requester i in bits [i*2 +: 2]
- `res_valid`  out  1  — result held on `res_data`/`res_id`
- `res_ready`  in  1  — consumer takes the result
- `res_data`  out  WIDTH  — operation result
- `res_id`  out  1  — index of the requester that issued the result
- `busy`  out  1  — high in any state other than IDLE
- `done_count`  out  CNT_W  — completed results (wraps)

## Operation
- Opcodes:
  - 00 = A & B
  - 01 = A | B
  - 10 = A ^ B
  - 11 = ~(A & B)
- FSM states are IDLE, EXEC and RESULT.
- **IDLE**
  - `grant` is computed combinationally from `req_valid` and the `last_grant` register.
  - One valid requester: it wins.
  - Both valid: the requester other than `last_grant` wins.
  - `req_ready[grant]` = 1 only when its `req_valid` is 1. `req_ready` is never 1 for both bits, and is 0 outside IDLE.
  - On handshake, A, B, op and the id are captured, `last_grant` ← grant, and the FSM goes to EXEC.
- **EXEC**
  - The logic unit output is registered into `res_data`; `res_id` ← the captured id.
  - Next state is RESULT.
- **RESULT**
  - `res_valid` = 1.
  - `res_data` and `res_id` stay stable until `res_ready` = 1.
  - On that handshake: `done_count` += 1 (mod 2^CNT_W), then go to IDLE.
- A requester may drop `req_valid` before it is granted. No commitment exists until the handshake, and the grant is re-evaluated every IDLE cycle.
- Operands are sampled only at handshake. Changes on `req_a`/`req_b`/`req_op` afterwards have no effect on the in-flight operation.
- Reset values:
  - State = IDLE.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - `req_ready` = 0, `res_valid` = 0, `res_data` = 0, `res_id` = 0, `busy` = 0, `done_count` = 0.
- Reset asserted mid-operation discards the captured operation. No result is emitted and `done_count` is not incremented.

## Timing
- A handshake in cycle N gives EXEC in N+1 and `res_valid` = 1 from N+2.
- With `res_ready` held at 1:
  - `res_valid` is high for exactly one cycle (N+2).
  - IDLE is at N+3, so the next accept is no earlier than N+3.
- Peak throughput is one operation per 3 cycles.
- Holding `res_ready` low stalls in RESULT indefinitely. `req_ready` stays 0 during the stall.
- `done_count` updates on the edge that ends the RESULT handshake cycle.
- `busy` is a registered decode of state; it is high in EXEC and RESULT.

## Structure
- Shared package `logic_unit_pkg` holds:
  - the opcode localparams (OP_AND, OP_OR, OP_XOR, OP_NAND)
  - the FSM state encoding (ST_IDLE, ST_EXEC, ST_RESULT)
- One sub-module, `logic_unit`: purely combinational, WIDTH-parameterised, inputs a, b, op; output y.
- The arbiter owns all registers, the FSM and the round-robin pointer.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both `req_valid` = 1 → all outputs 0, `req_ready` = 00 during reset. First grant after release goes to requester 0.
- **Single op:** requester 1 with A = 0xF0, B = 0x3C, op = 10 → `req_ready` = 10 in cycle N; `res_valid` at N+2 with `res_data` = 0xCC, `res_id` = 1; `done_count` = 1.
- **Contention:** both requesters valid continuously, `res_ready` = 1. Requester 0: A = 0xAA, B = 0x0F, op = 00. Requester 1: A = 0xAA, B = 0x0F, op = 11.
  - Grants alternate 0, 1, 0, 1.
  - Results alternate 0x0A / 0xF5.
  - Accepts are spaced 3 cycles apart.
- **Backpressure:** `res_ready` = 0 for 5 cycles in RESULT → `res_data`, `res_id` and `res_valid` stay stable; `req_ready` = 00; `done_count` is unchanged until the release cycle.
- **Mid-operation reset:** `rst` pulsed in the EXEC cycle → next cycle is IDLE, `res_valid` never asserts, `done_count` = 0.
- **Wrap and opcodes:** 256 completions with CNT_W = 8 → `done_count` returns to 0. Include op = 01 with A = 0x12, B = 0x40 → 0x52.
